// File: rtl/run_ctl.sv
// run_ctl: button-driven CPU run controller that clears, runs and freezes the CPU.
// It detects halts (PC unchanged) and enforces a watchdog. Define RUN_CTL_CYCLE_CNT_EN to add cycle_count_o.

module run_ctl_edge (
  input  logic clock_i,
  input  logic reset_ni,
  input  logic lvl_i,
  output logic rise_o
);
  logic prev_q;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) prev_q <= 1'b0;
    else           prev_q <= lvl_i;
  end

  assign rise_o = lvl_i & ~prev_q;
endmodule

module run_ctl #(
  parameter int CLR_CYC  = 4,
  parameter int HALT_WIN = 4,
  parameter int MAX_CYC  = 1000000
) (
  input  logic        clock_i,
  input  logic        reset_ni,
  input  logic        fib_act_i,
  input  logic        sort_act_i,
  input  logic        load_act_i,
  input  logic        save_act_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] cpu_result_i,
  output logic        cpu_reset_o,
  output logic        cpu_en_o,
  output logic [31:0] program_selector_o,
  output logic [31:0] data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o
`ifdef RUN_CTL_CYCLE_CNT_EN
  ,output logic [31:0] cycle_count_o
`endif
);
  localparam int NUM_BTN = 4;
  localparam int CW      = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
  localparam int SW      = $clog2(HALT_WIN + 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYC - 1);
  localparam logic [SW-1:0] HALT_LIM = SW'(HALT_WIN);
  localparam logic [31:0]   WDOG_LIM = 32'(MAX_CYC);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE, S_TIMEOUT} state_e;

  typedef struct packed {
    logic cpu_reset;
    logic cpu_en;
    logic busy;
    logic done;
    logic timeout;
  } ctl_t;

  localparam ctl_t CTL_IDLE  = ctl_t'(5'b10000);
  localparam ctl_t CTL_CLEAR = ctl_t'(5'b11100);
  localparam ctl_t CTL_RUN   = ctl_t'(5'b01100);
  localparam ctl_t CTL_DONE  = ctl_t'(5'b00010);
  localparam ctl_t CTL_TMO   = ctl_t'(5'b00001);

  state_e          state_q;
  ctl_t            ctl_q;
  logic [31:0]     prog_q;
  logic [31:0]     data_q;
  logic [CW-1:0]   clr_cnt_q;
  logic [31:0]     cyc_q, cyc_d;
  logic [SW-1:0]   same_q, same_d;
  logic [31:0]     pc_prev_q;
`ifdef RUN_CTL_CYCLE_CNT_EN
  logic [31:0]     cyc_lat_q;
`endif

  logic [NUM_BTN-1:0] btn_lvl, btn_rise;
  logic [31:0]        code;
  logic               restart, halt, wdog;

  assign btn_lvl = {save_act_i, load_act_i, sort_act_i, fib_act_i};

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    run_ctl_edge u_edge (
      .clock_i  (clock_i),
      .reset_ni (reset_ni),
      .lvl_i    (btn_lvl[b]),
      .rise_o   (btn_rise[b])
    );
  end

  // Lowest index wins: fib > sort > load > save, code = index + 1.
  always_comb begin
    code = '0;
    for (int b = NUM_BTN - 1; b >= 0; b--) begin
      if (btn_rise[b]) code = 32'(b + 1);
    end
  end

  // Presses during CLEAR are ignored; everywhere else they (re)start a program.
  assign restart = (|btn_rise) && (state_q != S_CLEAR);

  assign cyc_d  = (&cyc_q) ? cyc_q : cyc_q + 32'd1;
  assign same_d = (pc_i != pc_prev_q) ? '0 :
                  (&same_q)           ? same_q : same_q + SW'(1);
  assign halt   = (same_d >= HALT_LIM);
  assign wdog   = (cyc_d >= WDOG_LIM);

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= S_IDLE;
      ctl_q     <= CTL_IDLE;
      prog_q    <= '0;
      data_q    <= '0;
      clr_cnt_q <= '0;
      cyc_q     <= '0;
      same_q    <= '0;
      pc_prev_q <= '0;
`ifdef RUN_CTL_CYCLE_CNT_EN
      cyc_lat_q <= '0;
`endif
    end else if (restart) begin
      state_q   <= S_CLEAR;
      ctl_q     <= CTL_CLEAR;
      prog_q    <= code;
      clr_cnt_q <= '0;
`ifdef RUN_CTL_CYCLE_CNT_EN
      cyc_lat_q <= '0;
`endif
    end else begin
      unique case (state_q)
        S_CLEAR: begin
          if (clr_cnt_q == CLR_LAST) begin
            state_q   <= S_RUN;
            ctl_q     <= CTL_RUN;
            cyc_q     <= '0;
            same_q    <= '0;
            pc_prev_q <= pc_i;
          end else begin
            clr_cnt_q <= clr_cnt_q + CW'(1);
          end
        end
        S_RUN: begin
          cyc_q     <= cyc_d;
          same_q    <= same_d;
          pc_prev_q <= pc_i;
          data_q    <= cpu_result_i;
          // Halt is checked first so it wins a same-cycle watchdog expiry.
          if (halt) begin
            state_q <= S_DONE;
            ctl_q   <= CTL_DONE;
`ifdef RUN_CTL_CYCLE_CNT_EN
            cyc_lat_q <= cyc_d;
`endif
          end else if (wdog) begin
            state_q <= S_TIMEOUT;
            ctl_q   <= CTL_TMO;
            data_q  <= 32'hFFFF_FFFF;
`ifdef RUN_CTL_CYCLE_CNT_EN
            cyc_lat_q <= cyc_d;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_reset_o        = ctl_q.cpu_reset;
  assign cpu_en_o           = ctl_q.cpu_en;
  assign busy_o             = ctl_q.busy;
  assign done_o             = ctl_q.done;
  assign timeout_o          = ctl_q.timeout;
  assign program_selector_o = prog_q;
  assign data_o             = data_q;
`ifdef RUN_CTL_CYCLE_CNT_EN
  assign cycle_count_o      = cyc_lat_q;
`endif
endmodule
